// File: rtl/io_multi.sv
// io_multi: multi-channel memory-mapped I/O with latched outputs and enter-key gated reads
module io_multi #(
  parameter int DATA_W     = 32,
  parameter int N_IN       = 4,
  parameter int N_OUT      = 4,
  parameter int ADDR_W     = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic                    re,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       data_i,
  output logic [DATA_W-1:0]       data_o,
  output logic                    rd_valid,
  output logic                    stall_o,
  input  logic                    enter,
  input  logic [N_IN*DATA_W-1:0]  in_data,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic [N_OUT-1:0]        out_upd,
  output logic                    busy
);
  localparam int CW = DEB_CYCLES > 1 ? $clog2(DEB_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t            state;
  logic [ADDR_W-1:0] ch;
  logic              s1, sync, stable, stable_prev;
  logic [CW-1:0]     cnt;
  logic              enter_pulse;
  assign enter_pulse = stable & ~stable_prev;
  assign stall_o     = rst & ((state == IDLE & re) | state == WAIT);
  assign busy        = rst & (state != IDLE);
  // stable only follows sync after DEB_CYCLES consecutive disagreeing cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      {s1, sync, stable, stable_prev} <= '0;
      cnt <= '0;
    end else begin
      s1          <= enter;
      sync        <= s1;
      stable_prev <= stable;
      if (sync == stable) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        stable <= ~stable;
        cnt    <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_data <= '0;
      out_upd  <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) begin
        out_upd[k] <= we && addr == ADDR_W'(k);
        if (we && addr == ADDR_W'(k)) out_data[k*DATA_W +: DATA_W] <= data_i;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ch       <= '0;
      data_o   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: if (re) begin
          if (int'(addr) < N_IN) begin
            ch    <= addr;
            state <= WAIT;
          end else begin
            data_o   <= '0;
            rd_valid <= 1'b1;
            state    <= DONE;
          end
        end
        WAIT: if (enter_pulse) begin
          data_o   <= in_data[int'(ch)*DATA_W +: DATA_W];
          rd_valid <= 1'b1;
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_multi.sv
// tb_io_multi: directed vector table plus hand sequences for gated reads, debounce and reset
module tb_io_multi;
  logic         clk = 0, rst = 0, we = 0, re = 0, enter = 0;
  logic [3:0]   addr = 0;
  logic [31:0]  data_i = 0, data_o;
  logic         rd_valid, stall_o, busy;
  logic [127:0] in_data = 0, out_data;
  logic [3:0]   out_upd;
  logic [31:0]  model [4];
  int           n_chk = 0, n_fail = 0, comp;
  logic         got;

  typedef struct {
    logic we, re; logic [3:0] addr; logic [31:0] din;
    logic stall; logic [3:0] upd; logic rv; logic [31:0] dout;
  } vec_t;
  vec_t v [6];

  always #5 clk = ~clk;

  io_multi dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .data_i(data_i),
    .data_o(data_o), .rd_valid(rd_valid), .stall_o(stall_o), .enter(enter),
    .in_data(in_data), .out_data(out_data), .out_upd(out_upd), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string name);
    for (int k = 0; k < 4; k++) chk(name, out_data[k*32 +: 32], model[k]);
  endtask

  task automatic wait_done(input string name);
    got = 0;
    for (int c = 0; c < 12 && !got; c++) begin
      #1;
      got = rd_valid;
      if (!got) tick();
    end
    chk(name, got, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    v[0] = '{1, 0, 4'd2,  32'hDEADBEEF, 0, 4'b0100, 0, 32'h0};
    v[1] = '{1, 0, 4'd9,  32'h99999999, 0, 4'b0000, 0, 32'h0};
    v[2] = '{0, 1, 4'd7,  32'h0,        1, 4'b0000, 1, 32'h0};
    v[3] = '{1, 1, 4'd12, 32'h11111111, 1, 4'b0000, 1, 32'h0};
    v[4] = '{1, 0, 4'd3,  32'hCAFEF00D, 0, 4'b1000, 0, 32'h0};
    v[5] = '{1, 1, 4'd0,  32'h0F0F0F0F, 1, 4'b0001, 0, 32'h0};
    for (int k = 0; k < 4; k++) model[k] = 0;
    in_data = {32'h55AA55AA, 32'h0BADF00D, 32'h12345678, 32'hA0A0A0A0};

    tick(); tick();
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_busy", busy, 0);
    rst = 1;
    chk("rst_data_o", data_o, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_upd", out_upd, 0);
    chk_outs("rst_out_data");
    tick();

    // last vector is an in-range read plus write: it parks in WAIT, released below
    for (int i = 0; i < 5; i++) begin
      we = v[i].we; re = v[i].re; addr = v[i].addr; data_i = v[i].din;
      #1;
      chk("vec_stall", stall_o, v[i].stall);
      tick();
      we = 0; re = 0;
      if (v[i].we && v[i].addr < 4) model[v[i].addr] = v[i].din;
      #1;
      chk("vec_upd", out_upd, v[i].upd);
      chk("vec_rd_valid", rd_valid, v[i].rv);
      chk("vec_data_o", data_o, v[i].dout);
      chk_outs("vec_out_data");
      tick();
      chk("vec_upd_clear", out_upd, 0);
    end

    re = 1; addr = 1;
    for (int c = 0; c < 13; c++) begin
      if (c == 5) enter = 1;
      #1;
      if (c < 12) begin
        chk("gated_stall", stall_o, 1);
        chk("gated_no_rv", rd_valid, 0);
      end else begin
        chk("gated_rv", rd_valid, 1);
        chk("gated_data", data_o, 32'h12345678);
        chk("gated_stall_done", stall_o, 0);
      end
      tick();
    end
    re = 0;
    #1;
    chk("gated_idle", busy, 0);
    enter = 0;
    repeat (10) tick();

    re = 1; addr = 2;
    tick();
    enter = 1;
    repeat (3) tick();
    enter = 0;
    comp = 0;
    repeat (12) begin
      #1;
      if (rd_valid) comp++;
      tick();
    end
    chk("glitch_no_completion", comp, 0);
    chk("glitch_still_stalled", stall_o, 1);
    enter = 1;
    comp = 0;
    repeat (16) begin
      #1;
      if (rd_valid) begin
        comp++;
        re = 0;
        chk("deb_data", data_o, 32'h0BADF00D);
      end
      tick();
    end
    chk("deb_one_completion", comp, 1);
    re = 0; enter = 0;
    repeat (10) tick();

    enter = 1;
    repeat (10) tick();
    re = 1; addr = 3;
    comp = 0;
    repeat (8) begin
      #1;
      if (rd_valid) comp++;
      tick();
    end
    chk("idle_press_discarded", comp, 0);
    chk("idle_press_stall", stall_o, 1);
    enter = 0;
    repeat (8) tick();
    chk("release_still_waiting", busy, 1);
    enter = 1;
    wait_done("fresh_press_done");
    chk("fresh_press_data", data_o, 32'h55AA55AA);
    re = 0;
    tick();
    enter = 0;
    repeat (10) tick();

    we = 1; re = 1; addr = 1; data_i = 32'hFEEDFACE;
    #1;
    chk("wr_rd_stall", stall_o, 1);
    tick();
    we = 0;
    model[1] = 32'hFEEDFACE;
    #1;
    chk("wr_rd_upd", out_upd, 4'b0010);
    chk("wr_rd_out", out_data[63:32], 32'hFEEDFACE);
    chk("wr_rd_busy", busy, 1);
    enter = 1;
    wait_done("wr_rd_done");
    chk("wr_rd_data", data_o, 32'h12345678);
    re = 0;
    tick();
    enter = 0;
    repeat (10) tick();

    re = 1; addr = 0;
    tick(); tick();
    chk("pre_rst_busy", busy, 1);
    rst = 0;
    #1;
    chk("mid_rst_stall", stall_o, 0);
    chk("mid_rst_busy", busy, 0);
    tick(); tick();
    rst = 1; re = 0;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_stall", stall_o, 0);
    chk("post_rst_data_o", data_o, 0);
    chk("post_rst_rd_valid", rd_valid, 0);
    chk("post_rst_upd", out_upd, 0);
    for (int k = 0; k < 4; k++) model[k] = 0;
    chk_outs("post_rst_out_data");
    enter = 1;
    comp = 0;
    repeat (12) begin
      #1;
      if (rd_valid) comp++;
      tick();
    end
    chk("abandoned_read", comp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/io_multi.md
# io_multi

Parametrised multi-channel memory-mapped I/O unit for the OpenMIPS SOPC. It replaces the single-register display/switch path with N_OUT latched output channels and N_IN input channels. Reads are gated by a debounced operator "enter" key; the unit stalls the core pipeline until the key is pressed. It sits beside data_ram on the core's I/O port (io_we/io_re/data lines plus the stall request).

## Interface
- DATA_W, 32, width of every data channel
- N_IN, 4, number of input channels (1..16)
- N_OUT, 4, number of output channels (1..16)
- ADDR_W, 4, channel-select width; must satisfy 2^ADDR_W >= max(N_IN, N_OUT)
- DEB_CYCLES, 4, stable cycles required before the enter key changes level (>=1)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, synchronous, active-low
- we  in  1  write strobe from core
- re  in  1  read request from core; held high by core while stalled
- addr  in  ADDR_W  channel select
- data_i  in  DATA_W  write data from core
- data_o  out  DATA_W  read data to core
- rd_valid  out  1  data_o valid this cycle (read completion)
- stall_o  out  1  pipeline stall request
- enter  in  1  raw asynchronous push-button, active-high
- in_data  in  N_IN*DATA_W  input channels; channel k = bits [k*DATA_W +: DATA_W]
- out_data  out  N_OUT*DATA_W  output channel registers, same packing
- out_upd  out  N_OUT  one-cycle pulse per channel on register update
- busy  out  1  FSM not in IDLE

## Operation
- Reset (rst=0 at an edge): out_data=0, out_upd=0, data_o=0, rd_valid=0, FSM=IDLE, synchroniser/debounce state=0, debounce counter=0. stall_o=0 and busy=0 whenever rst=0.
- Write: we=1 and addr<N_OUT -> out_data[addr] <= data_i, out_upd[addr]=1 in the following cycle. addr>=N_OUT -> write ignored, no pulse. Writes are accepted in every FSM state.
- Enter filter: 2-flop synchroniser -> sync. The counter increments while sync != stable and clears when they are equal. When the counter reaches DEB_CYCLES-1 with sync != stable, stable toggles at that edge and the counter clears. enter_pulse = stable & ~stable_prev (one cycle).
- FSM states are IDLE, WAIT, DONE.
  - IDLE: on re=1 with addr<N_IN, latch ch=addr and go to WAIT. On re=1 with addr>=N_IN, set data_o<=0 and go to DONE. enter_pulse in IDLE is discarded; it is never queued.
  - WAIT: on enter_pulse, data_o <= in_data[ch] sampled at that edge, then go to DONE. Otherwise stay in WAIT. re and addr are ignored here.
  - DONE: rd_valid=1, then go to IDLE unconditionally. re seen in DONE is ignored.
- stall_o is combinational: (state==IDLE & re) | (state==WAIT).
- busy = (state != IDLE).
- data_o holds its last read value until the next completion.
- Simultaneous we and re: both act independently. A write to channel k and a read of input k in the same cycle do not interact (separate register files).

## Timing
- Write latency: out_data and out_upd change 1 cycle after the cycle in which we is sampled.
- Enter latency: raw enter rising in cycle t and held -> enter_pulse in cycle t+2+DEB_CYCLES. A glitch shorter than DEB_CYCLES cycles at sync produces no pulse. Release is filtered the same way.
- Read with enter: re in cycle 0 gives stall_o=1 in cycle 0. The FSM is in WAIT from cycle 1. With enter_pulse in cycle p, the FSM is in DONE in cycle p+1: rd_valid=1 and stall_o=0. The FSM is back in IDLE in cycle p+2.
- Minimum read latency: 2 cycles; an out-of-range read completes in cycle 1.
- Reset mid-WAIT: FSM returns to IDLE, stall_o drops the same cycle rst=0 is sampled, and the pending read is abandoned.

## Test plan
- Reset: drive rst=0 for 2 cycles after arbitrary activity -> all outputs 0, busy=0, stall_o=0.
- Write channels: we, addr=2, data_i=0xDEADBEEF -> next cycle out_data ch2=0xDEADBEEF and out_upd=4'b0100 for one cycle. Then we, addr=9 (N_OUT=4) -> no register change, out_upd=0.
- Gated read: in_data ch1=0x12345678, re=1 addr=1 held; raise enter at cycle 5 (DEB_CYCLES=4) -> stall_o=1 for cycles 0..11. In cycle 12: rd_valid=1, data_o=0x12345678, stall_o=0.
- Debounce: in WAIT, pulse enter high for 3 cycles -> no completion. Then hold it for 10 cycles -> exactly one completion.
- Out-of-range read: re, addr=7 (N_IN=4) -> stall_o=1 in cycle 0; cycle 1 gives rd_valid=1 and data_o=0 with no enter needed.
- Corner cases:
  - Enter pressed in IDLE, then re -> still waits for a fresh press.
  - rst=0 during WAIT -> IDLE and stall_o=0 immediately.
  - we+re in the same cycle -> both take effect.
